id_stage_ctrl: RTL
==================

# id_stage_ctrl

Decode-stage controller for the 5-stage RV32I core. It accepts instructions from the IF/ID register through a valid/ready handshake and decodes them into control signals. It owns the ID/EXE pipeline register: instruction word (feeding the immediate generator), PC, register indices and the control bundle. It inserts load-use bubbles, discards wrong-path instructions after an EXE redirect, and keeps saturating stall/flush counters.

## Interface
- FLUSH_CYCLES, 1: cycles after a redirect during which accepted IF instructions are discarded (1..7).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_valid  in  1  IF/ID holds an instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction PC
- if_ready  out  1  ID consumes IF/ID entry this cycle (combinational)
- ex_ready  in  1  EXE accepts the current ID/EXE contents
- ex_flush  in  1  taken branch/jump resolved in EXE; qualified by ex_ready
- idex_valid  out  1  ID/EXE register valid
- idex_instr  out  32  raw instruction to immediate generator
- idex_pc  out  32
- idex_rd, idex_rs1, idex_rs2  out  5 each
- idex_funct3  out  3
- idex_ctrl  out  ctrl_t  {alu_imm, mem_read, mem_write, reg_write, branch, jump, illegal}
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- adv = !idex_valid || ex_ready; ID/EXE loads only when adv.
- Decode by opcode:
  - R 0110011 and S 0100011 and B 1100011 use rs1 and rs2.
  - I 0010011, LOAD 0000011 and JALR 1100111 use rs1 only.
  - LUI 0110111, AUIPC 0010111 and JAL 1101111 use neither.
  - Any other opcode: ctrl all zero except illegal=1; it still passes as valid.
- hazard = if_valid && idex_valid && idex_ctrl.mem_read && idex_rd!=0 && (rs1 used && rs1==idex_rd || rs2 used && rs2==idex_rd).
- FSM states:
  - RUN:
    - if_ready = adv && !hazard.
    - On adv && hazard: load a bubble (idex_valid=0, ctrl=0) and increment stall_cnt.
    - On adv && !hazard: load the decoded if_instr, with idex_valid = if_valid.
  - FLUSH:
    - if_ready=1. Any if_valid entry is consumed and discarded.
    - idex_valid is held 0.
    - A down-counter loaded with FLUSH_CYCLES decrements each cycle; at 1, go to RUN.
- Transition RUN→FLUSH on ex_flush && ex_ready:
  - ID/EXE loads a bubble.
  - The IF entry this cycle is discarded (if_ready=1).
  - flush_cnt increments.
- ex_flush in FLUSH state restarts the counter at FLUSH_CYCLES and increments flush_cnt again.
- ex_flush without ex_ready is ignored.
- Simultaneous flush and hazard: the flush wins and stall_cnt is not incremented.
- Counters saturate at all-ones and never wrap.
- x0 as destination never triggers a hazard.

## Timing
- Reset (rst_n=0, asynchronous):
  - idex_valid=0; all idex_* = 0; counters = 0; state RUN.
  - if_ready=0 while rst_n=0.
- Latency: 1 cycle from the IF handshake (if_valid && if_ready) to idex_valid=1.
- Load-use costs exactly one bubble when ex_ready=1 throughout; the dependent instruction is accepted on the next cycle.
- While ex_ready=0 with idex_valid=1, all idex_* outputs stay stable.
- After ex_flush, the first new instruction can be accepted FLUSH_CYCLES+1 cycles later.
- Deasserting rst_n mid-stall or mid-flush clears everything; the next cycle behaves as RUN with an empty register.

## Structure
- Package id_pkg holds:
  - ctrl_t packed struct.
  - Opcode localparams (OP_R, OP_I, OP_LOAD, OP_JALR, OP_S, OP_B, OP_LUI, OP_AUIPC, OP_JAL), shared with the immediate generator.
  - state_t enum {RUN, FLUSH}.
- Sub-module id_decode: combinational opcode → ctrl_t plus rs1_used/rs2_used. The FSM, hazard logic, register and counters stay in the top.

## Test plan
- Reset: hold rst_n=0 mid-stream with idex_valid=1 → all outputs 0 immediately. After release, ADDI 0x00500093 in cycle 1 → idex_valid=1 in cycle 2 with rd=1, alu_imm=1, reg_write=1.
- Load-use: LW x5,0(x1) then ADD x6,x5,x2, ex_ready=1 → bubble cycle with idex_valid=0 and if_ready=0 for one cycle. ADD issues the next cycle; stall_cnt=1.
- No false hazard:
  - LW x0 followed by a use of x0 → no bubble.
  - LW x5 followed by LUI x5 → no bubble.
- Backpressure: ex_ready=0 for 3 cycles with idex_valid=1 → idex_instr unchanged and if_ready=0. The next instruction loads on the cycle after ex_ready rises.
- Flush with FLUSH_CYCLES=2: ex_flush&&ex_ready while if_valid=1 → next idex_valid=0 and 3 consecutive IF entries discarded; flush_cnt=1. A second flush during FLUSH restarts the window, giving flush_cnt=2. Flush coincident with a hazard leaves stall_cnt unchanged.
- Illegal opcode 0x0000007F → idex_valid=1, ctrl.illegal=1, all other ctrl bits 0. Counter saturation with CNT_W=2: 5 hazards → stall_cnt=3.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode-stage types: control bundle, opcodes, FSM states.
// Opcode constants are also used by the immediate generator.
package id_pkg;

  typedef struct packed {
    logic alu_imm;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic branch;
    logic jump;
    logic illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    ctrl_t       ctrl;
  } id_ex_t;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

endpackage

// File: rtl/id_decode.sv
// Opcode decoder: control bundle plus source-register usage.
// Unknown opcodes raise illegal with all other controls clear.
module id_decode
  import id_pkg::*;
(
  input  logic [6:0] opcode,
  output ctrl_t      ctrl,
  output logic       rs1_used,
  output logic       rs2_used
);

  always_comb begin
    ctrl     = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    unique case (1'b1)
      opcode == OP_R: begin
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      opcode == OP_S: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.mem_write = 1'b1;
        rs1_used       = 1'b1;
        rs2_used       = 1'b1;
      end
      opcode == OP_B: begin
        ctrl.branch = 1'b1;
        rs1_used    = 1'b1;
        rs2_used    = 1'b1;
      end
      opcode == OP_I: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      opcode == OP_LOAD: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      opcode == OP_JALR: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
        rs1_used       = 1'b1;
      end
      opcode == OP_LUI,
      opcode == OP_AUIPC: begin
        ctrl.alu_imm   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      opcode == OP_JAL: begin
        ctrl.jump      = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF handshake, ID/EXE register,
// load-use bubbles, redirect flush window, stall/flush counters.
module id_stage_ctrl
  import id_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  input  logic [31:0]      if_instr,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  input  logic             ex_ready,
  input  logic             ex_flush,
  output logic             idex_valid,
  output logic [31:0]      idex_instr,
  output logic [31:0]      idex_pc,
  output logic [4:0]       idex_rd,
  output logic [4:0]       idex_rs1,
  output logic [4:0]       idex_rs2,
  output logic [2:0]       idex_funct3,
  output ctrl_t            idex_ctrl,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t     state_q;
  state_t     state_d;
  logic [2:0] fcnt_q;
  logic [2:0] fcnt_d;
  id_ex_t     idex_q;
  logic       valid_q;

  ctrl_t      dec_ctrl;
  logic       rs1_used;
  logic       rs2_used;

  logic       adv;
  logic       flush;
  logic       hazard;
  logic       rdy;
  logic       load;
  logic       load_instr;
  logic       stall_inc;
  logic       flush_inc;

  id_decode u_dec (
    .opcode   (if_instr[6:0]),
    .ctrl     (dec_ctrl),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  assign idex_valid  = valid_q;
  assign idex_instr  = idex_q.instr;
  assign idex_pc     = idex_q.pc;
  assign idex_ctrl   = idex_q.ctrl;
  assign idex_rd     = idex_q.instr[11:7];
  assign idex_rs1    = idex_q.instr[19:15];
  assign idex_rs2    = idex_q.instr[24:20];
  assign idex_funct3 = idex_q.instr[14:12];

  assign adv   = !valid_q || ex_ready;
  assign flush = ex_flush && ex_ready;

  // x0 never carries a real load result, so it cannot cause a stall
  assign hazard = if_valid && valid_q
               && idex_q.ctrl.mem_read
               && (idex_rd != 5'd0)
               && ((rs1_used && if_instr[19:15] == idex_rd)
                || (rs2_used && if_instr[24:20] == idex_rd));

  assign if_ready = rst_n && rdy;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    rdy        = 1'b0;
    load       = 1'b0;
    load_instr = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (flush) begin
          rdy       = 1'b1;
          load      = 1'b1;
          state_d   = FLUSH;
          fcnt_d    = FC;
          flush_inc = 1'b1;
        end else if (adv) begin
          load       = 1'b1;
          rdy        = !hazard;
          stall_inc  = hazard;
          load_instr = !hazard && if_valid;
        end
      end
      FLUSH: begin
        rdy  = 1'b1;
        load = 1'b1;
        if (flush) begin
          fcnt_d    = FC;
          flush_inc = 1'b1;
        end else if (fcnt_q == 3'd1) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      fcnt_q  <= '0;
      valid_q <= 1'b0;
      idex_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      if (load) begin
        valid_q <= load_instr;
        if (load_instr) begin
          idex_q <= '{instr: if_instr, pc: if_pc, ctrl: dec_ctrl};
        end else begin
          idex_q <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && stall_cnt != '1) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush_inc && flush_cnt != '1) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule
